// File: rtl/serial_compar_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_compar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    localparam int unsigned DIGIT_W = 2;

    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_LT = 2'b01;
    localparam logic [1:0] RES_GT = 2'b10;

endpackage

// File: rtl/serial_compar_compar_2b.sv
// compar_2b: combinational 2-bit unsigned magnitude comparator (digit stage).
module compar_2b (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       A_gt_B,
    output logic       A_eq_B,
    output logic       A_lt_B
);

    assign A_gt_B = (A > B);
    assign A_eq_B = (A == B);
    assign A_lt_B = (A < B);

endmodule

// File: rtl/serial_compar.sv
// serial_compar: MSB-first multi-cycle unsigned comparator, one 2-bit digit per cycle.
// Define SERIAL_COMPAR_EARLY_EXIT_EN to finish on the first differing digit.
module serial_compar
    import serial_compar_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             busy
);

    localparam int NDIG = WIDTH / 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_compar: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             diff_found;
    logic [1:0]       res;
    logic             dig_gt;
    logic             dig_eq;
    logic             dig_lt;

    compar_2b u_digit (
        .A      (sa[WIDTH-1 -: DIGIT_W]),
        .B      (sb[WIDTH-1 -: DIGIT_W]),
        .A_gt_B (dig_gt),
        .A_eq_B (dig_eq),
        .A_lt_B (dig_lt)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE: if (start_valid) next = CMP;
            CMP: begin
                if (cnt == '0) next = DONE;
`ifdef SERIAL_COMPAR_EARLY_EXIT_EN
                if (!dig_eq && !diff_found) next = DONE;
`endif
            end
            DONE: if (res_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            cnt        <= '0;
            diff_found <= 1'b0;
            res        <= RES_EQ;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        sa         <= A;
                        sb         <= B;
                        cnt        <= CW'(NDIG - 1);
                        diff_found <= 1'b0;
                        res        <= RES_EQ;
                    end
                end
                CMP: begin
                    // Only the most significant differing digit decides the result.
                    if (!dig_eq && !diff_found) begin
                        res        <= {dig_gt, dig_lt};
                        diff_found <= 1'b1;
                    end
                    sa  <= sa << DIGIT_W;
                    sb  <= sb << DIGIT_W;
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == DONE);
    assign A_gt_B      = res_valid && (res == RES_GT);
    assign A_lt_B      = res_valid && (res == RES_LT);
    assign A_eq_B      = res_valid && !diff_found;

endmodule

// File: tb/tb_serial_compar.sv
// Self-checking bench for serial_compar at WIDTH=8 (directed/random) and WIDTH=4 (exhaustive).
module tb_serial_compar;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       sv8, sr8, rv8, rr8, gt8, eq8, lt8, busy8;
    logic [7:0] a8, b8;
    logic       sv4, sr4, rv4, rr4, gt4, eq4, lt4, busy4;
    logic [3:0] a4, b4;

    int checks = 0;
    int errors = 0;

    serial_compar #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
        .A(a8), .B(b8), .res_valid(rv8), .res_ready(rr8),
        .A_gt_B(gt8), .A_eq_B(eq8), .A_lt_B(lt8), .busy(busy8)
    );

    serial_compar #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
        .A(a4), .B(b4), .res_valid(rv4), .res_ready(rr4),
        .A_gt_B(gt4), .A_eq_B(eq4), .A_lt_B(lt4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: flags {gt,eq,lt} from plain arithmetic.
    function automatic logic [2:0] exp_flags(input int unsigned a, input int unsigned b);
        return {a > b, a == b, a < b};
    endfunction

    // Reference latency in CMP cycles from accept edge to res_valid.
    function automatic int exp_lat(input int unsigned a, input int unsigned b, input int nd);
        int lat = nd;
`ifdef SERIAL_COMPAR_EARLY_EXIT_EN
        bit found = 1'b0;
        for (int i = 0; i < nd; i++) begin
            int unsigned sh = 2 * (nd - 1 - i);
            if (!found && (((a >> sh) % 4) != ((b >> sh) % 4))) begin
                lat = i + 1;
                found = 1'b1;
            end
        end
`endif
        return lat;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        a8 = a; b8 = b; sv8 = 1'b1; rr8 = 1'b1;
        check({tag, ":ready"}, 32'(sr8), 32'(1));
        @(posedge clk); #1;
        sv8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 0;
        while (!rv8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":lat"}, 32'(n), 32'(exp_lat(a, b, 4)));
        check({tag, ":flags"}, 32'({gt8, eq8, lt8}), 32'(exp_flags(a, b)));
        @(posedge clk); #1;
        check({tag, ":idle"}, 32'({rv8, gt8, eq8, lt8, busy8}), 32'(0));
    endtask

    initial begin
        int n;
        int prev_acc;
        int prev_lat;
        rst = 1'b1;
        sv8 = 1'b0; rr8 = 1'b1; a8 = '0; b8 = '0;
        sv4 = 1'b0; rr4 = 1'b1; a4 = '0; b4 = '0;

        // Reset state, and start_valid ignored while rst is high.
        @(posedge clk); #1;
        check("rst8_out", 32'({rv8, gt8, eq8, lt8, busy8}), 32'(0));
        check("rst8_ready", 32'(sr8), 32'(1));
        check("rst4_out", 32'({rv4, gt4, eq4, lt4, busy4}), 32'(0));
        sv8 = 1'b1; a8 = 8'h55;
        @(posedge clk); #1;
        check("rst8_nocap", 32'(busy8), 32'(0));
        sv8 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run8(8'hA5, 8'hA5, "eq_a5");
        run8(8'h80, 8'h7F, "gt_80_7f");
        run8(8'h12, 8'h13, "lt_12_13");
        run8(8'h00, 8'h00, "eq_zero");
        run8(8'hFF, 8'hFF, "eq_ones");

        // Back-pressure in DONE with start_valid pulsed.
        a8 = 8'h3C; b8 = 8'hC3; sv8 = 1'b1; rr8 = 1'b0;
        @(posedge clk); #1;
        sv8 = 1'b0;
        n = 0;
        while (!rv8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", 32'(n), 32'(exp_lat(8'h3C, 8'hC3, 4)));
        for (int i = 0; i < 5; i++) begin
            sv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            check("bp_hold", 32'({rv8, gt8, eq8, lt8, busy8, sr8}), 32'(6'b1_001_1_0));
            @(posedge clk); #1;
        end
        sv8 = 1'b0;
        check("bp_hold_end", 32'({rv8, gt8, eq8, lt8}), 32'(4'b1_001));
        rr8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({rv8, gt8, eq8, lt8, busy8, sr8}), 32'(6'b0_000_0_1));
        @(posedge clk); #1;
        check("bp_nocap", 32'(busy8), 32'(0));

        // Reset in the second CMP cycle aborts the operation.
        a8 = 8'hFF; b8 = 8'h00; sv8 = 1'b1; rr8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        @(posedge clk); #1;
        check("midrst_pre", 32'(busy8), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_out", 32'({rv8, gt8, eq8, lt8, busy8, sr8}), 32'(6'b0_000_0_1));
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_after", 32'({rv8, gt8, eq8, lt8, busy8}), 32'(0));
        run8(8'h03, 8'h30, "post_rst_lt");

        // Random WIDTH=8 operand pairs.
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), "rand8");
        end

        // Exhaustive WIDTH=4, back-to-back, with period check between accepts.
        prev_acc = -1;
        prev_lat = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b); sv4 = 1'b1; rr4 = 1'b1;
                check("w4_ready", 32'(sr4), 32'(1));
                @(posedge clk); #1;
                if (prev_acc >= 0) check("w4_period", 32'(cyc - prev_acc), 32'(prev_lat + 2));
                prev_acc = cyc;
                prev_lat = exp_lat(a, b, 2);
                sv4 = 1'b0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                n = 0;
                while (!rv4 && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("w4_lat", 32'(n), 32'(prev_lat));
                check("w4_flags", 32'({gt4, eq4, lt4}), 32'(exp_flags(a, b)));
                check("w4_onehot", 32'($countones({gt4, eq4, lt4})), 32'(1));
                @(posedge clk); #1;
                check("w4_idle", 32'({rv4, gt4, eq4, lt4, busy4}), 32'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
